// File: rtl/aixh_mxc_upper_bwd_sink_if.sv
// Handshake bundle for the upper backward sink: repeater input,
// collection control/status, and consumer output.
`ifndef UPCELL_BWD_DWIDTH
`define UPCELL_BWD_DWIDTH 32
`endif

interface aixh_mxc_upper_bwd_sink_if #(
    parameter int DEPTH  = 8,
    parameter int DWIDTH = `UPCELL_BWD_DWIDTH
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              i_bwd_vld;
    logic [DWIDTH-1:0] i_bwd_dat;
    logic              i_start;
    logic [15:0]       i_exp_cnt;
    logic              i_clr;
    logic              o_dat_vld;
    logic [DWIDTH-1:0] o_dat;
    logic              i_dat_rdy;
    logic [CW-1:0]     o_cnt;
    logic              o_done;
    logic              o_busy;
    logic              o_ovf;

    modport slave (
        input  i_bwd_vld, i_bwd_dat,
        input  i_start, i_exp_cnt, i_clr,
        input  i_dat_rdy,
        output o_dat_vld, o_dat, o_cnt,
        output o_done, o_busy, o_ovf
    );

    modport master (
        output i_bwd_vld, i_bwd_dat,
        output i_start, i_exp_cnt, i_clr,
        output i_dat_rdy,
        input  o_dat_vld, o_dat, o_cnt,
        input  o_done, o_busy, o_ovf
    );
endinterface

// File: rtl/aixh_mxc_upper_bwd_sink.sv
// Backward-data sink FIFO with word-count collection FSM.
// Define AIXH_MXC_UPPER_BWD_SINK_OVF_EN for the sticky overflow flag.
`ifndef UPCELL_BWD_DWIDTH
`define UPCELL_BWD_DWIDTH 32
`endif

module aixh_mxc_upper_bwd_sink #(
    parameter int DEPTH  = 8,
    parameter int DWIDTH = `UPCELL_BWD_DWIDTH
) (
    input  logic aixh_core_clk2x,
    input  logic aixh_core_rstn,
    aixh_mxc_upper_bwd_sink_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, RUN} state_t;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    state_t            state_q, state_d;
    logic [15:0]       rem_q, rem_d;
    logic              done_q, done_d;

    logic full, push, pop, clr;

    assign clr  = bus.i_clr;
    assign full = (cnt_q == CW'(DEPTH));
    assign pop  = bus.o_dat_vld && bus.i_dat_rdy;
    // A full buffer still takes a word if the head leaves this cycle.
    assign push = bus.i_bwd_vld && (!full || pop);

    assign bus.o_dat_vld = (cnt_q != '0);
    assign bus.o_dat     = mem[rptr_q];
    assign bus.o_cnt     = cnt_q;
    assign bus.o_done    = done_q;
    assign bus.o_busy    = (state_q == RUN);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clr) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) wptr_d = wptr_q + AW'(1);
            if (pop)  rptr_d = rptr_q + AW'(1);
            unique case (1'b1)
                push && !pop: cnt_d = cnt_q + CW'(1);
                pop && !push: cnt_d = cnt_q - CW'(1);
                default:      cnt_d = cnt_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        if (clr) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (bus.i_start) begin
                    if (bus.i_exp_cnt == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        rem_d   = bus.i_exp_cnt;
                    end
                end
                RUN: if (pop) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge aixh_core_clk2x) begin
        if (!aixh_core_rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    // Storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge aixh_core_clk2x) begin
        if (push && !clr) mem[wptr_q] <= bus.i_bwd_dat;
    end

`ifdef AIXH_MXC_UPPER_BWD_SINK_OVF_EN
    logic ovf_q;
    logic drop;

    assign drop      = bus.i_bwd_vld && full && !pop;
    assign bus.o_ovf = ovf_q;

    always_ff @(posedge aixh_core_clk2x) begin
        if (!aixh_core_rstn || clr) ovf_q <= 1'b0;
        else if (drop)              ovf_q <= 1'b1;
    end
`else
    assign bus.o_ovf = 1'b0;
`endif

endmodule

// File: doc/aixh_mxc_upper_bwd_sink.md
AIXH_MXC_UPPER_BWD_SINK -- requirements
Module: aixh_mxc_upper_bwd_sink

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning buffer entries (power of 2, 4..64).
REQ-002 SHALL have parameter DWIDTH, default UPCELL_BWD_DWIDTH, meaning backward data width.
REQ-003 SHALL have port aixh_core_clk2x  input  1  meaning single clock; all logic on its rising edge.
REQ-004 SHALL have port aixh_core_rstn  input  1  meaning reset, synchronous and active-low.
REQ-005 SHALL have port i_bwd_vld  input  1  meaning word valid from the last backward repeater stage; no backpressure.
REQ-006 SHALL have port i_bwd_dat  input  DWIDTH  meaning backward word.
REQ-007 SHALL have port i_start  input  1  meaning pulse that starts a collection of i_exp_cnt words.
REQ-008 SHALL have port i_exp_cnt  input  16  meaning expected word count, sampled on i_start.
REQ-009 SHALL have port i_clr  input  1  meaning flush buffer, clear the sticky overflow flag, return FSM to IDLE.
REQ-010 SHALL have port o_dat_vld  output  1  meaning head word valid to consumer.
REQ-011 SHALL have port o_dat  output  DWIDTH  meaning head word.
REQ-012 SHALL have port i_dat_rdy  input  1  meaning consumer ready; pop when o_dat_vld and i_dat_rdy are both high.
REQ-013 SHALL have port o_cnt  output  $clog2(DEPTH)+1  meaning buffer occupancy.
REQ-014 SHALL have port o_done  output  1  meaning one-cycle pulse when the collection completes.
REQ-015 SHALL have port o_busy  output  1  meaning FSM is in RUN.
REQ-016 SHALL have port o_ovf  output  1  meaning sticky overflow flag.

Function
REQ-017 SHALL push i_bwd_dat whenever i_bwd_vld=1 and the buffer is not full, or when the buffer is full and a pop occurs in the same cycle.
REQ-018 SHALL present a pushed word on o_dat_vld/o_dat exactly 1 cycle after the push when the buffer was empty; there is no combinational bypass.
REQ-019 SHALL hold o_dat stable while o_dat_vld=1 and i_dat_rdy=0.
REQ-020 SHALL deliver words in arrival order; read and write pointers wrap modulo DEPTH.
REQ-021 SHALL keep o_cnt unchanged on a simultaneous push and pop, increment it on push only, and decrement it on pop only.
REQ-022 SHALL drop a word when i_bwd_vld=1, the buffer is full and there is no pop; buffer contents and pointers SHALL stay unchanged.
REQ-023 SHALL implement the FSM IDLE->RUN on i_start, loading remaining=i_exp_cnt.
REQ-024 SHALL, in RUN, decrement remaining on each pop, and on the pop that takes remaining from 1 to 0, assert o_done for 1 cycle and return to IDLE.
REQ-025 SHALL treat i_start with i_exp_cnt=0 as immediate completion: o_done pulses the next cycle and the FSM stays in IDLE.
REQ-026 SHALL ignore i_start while in RUN.
REQ-027 SHALL still accept pushes and pops in IDLE; pops in IDLE SHALL NOT be counted.
REQ-028 SHALL give i_clr priority over i_start, push and pop in the same cycle: the buffer is emptied, the FSM goes to IDLE and o_done stays 0.

Reset
REQ-029 SHALL, on aixh_core_rstn=0 at a clock edge, set o_dat_vld=0, o_cnt=0, o_done=0, o_busy=0, o_ovf=0, set the pointers to 0 and put the FSM in IDLE.
REQ-030 SHALL discard buffered words and an in-progress collection when reset is asserted mid-operation; the contents of o_dat and of the storage array are don't-care after reset.

Configuration
REQ-031 SHALL, with AIXH_MXC_UPPER_BWD_SINK_OVF_EN defined, set o_ovf on any dropped word (REQ-022) and hold it until i_clr or reset.
REQ-032 SHALL, without AIXH_MXC_UPPER_BWD_SINK_OVF_EN, tie o_ovf to 0 with no overflow logic; drop behaviour is otherwise identical.

Verification
REQ-033 SHALL cover: DEPTH=8, i_dat_rdy=1, single push of 0xA5 -> o_dat_vld=1 with o_dat=0xA5 one cycle later, o_cnt back to 0 after the pop.
REQ-034 SHALL cover: i_dat_rdy=0, 10 consecutive pushes -> o_cnt=8, o_ovf=1 (macro on) or o_ovf=0 (macro off), draining yields words 1..8 in order.
REQ-035 SHALL cover: buffer full, simultaneous push and pop -> word accepted, o_cnt stays 8, o_ovf stays 0.
REQ-036 SHALL cover: i_start with i_exp_cnt=5, then 5 words pushed and popped -> o_done pulses on the 5th pop cycle, o_busy=1 through cycles 1..5, then 0.
REQ-037 SHALL cover: i_start with i_exp_cnt=0 -> o_done pulse next cycle, o_busy never 1.
REQ-038 SHALL cover: RUN with 3 words buffered, then i_clr together with i_bwd_vld=1 -> o_cnt=0, o_dat_vld=0, FSM in IDLE, o_ovf=0, no o_done.
